// File: rtl/muxn_scan_en.sv
// muxn_scan_en -- registered N-channel, W-bit selector with enable.
//
// Purpose:
//   Selects one of NCH packed input channels and registers it with one cycle of
//   latency. There are two select modes:
//     manual (mode=0) : the channel comes from the select input.
//     scan   (mode=1) : the channel advances round-robin, dwelling DWELL cycles
//                       on each channel.
//   cur_sel and scan_wrap tag each output sample for the monitor/readout path.
//
// Ports:
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   en         in   1        block enable
//   mode       in   1        0 = manual select, 1 = scan
//   select     in   SELW     manual channel index
//   d          in   NCH*W    packed inputs; channel k = d[k*W +: W]
//   q          out  W        registered selected data
//   q_valid    out  1        q holds a valid sample
//   cur_sel    out  SELW     channel index that produced the current q
//   scan_wrap  out  1        one-cycle tag on the first channel-0 sample after a wrap
//   sel_err    out  1        out-of-range manual select was sampled (sticky)
//
// Configuration macro:
//   MUXN_HOLD_EN  defined   : en=0 holds q and cur_sel, q_valid drops.
//                 undefined : en=0 clears q and q_valid, cur_sel holds.
module muxn_scan_en #(
   parameter  int NCH   = 4,
   parameter  int W     = 8,
   parameter  int DWELL = 4,
   localparam int SELW  = $clog2(NCH)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                mode,
   input  logic [SELW-1:0]     select,
   input  logic [NCH*W-1:0]    d,
   output logic [W-1:0]        q,
   output logic                q_valid,
   output logic [SELW-1:0]     cur_sel,
   output logic                scan_wrap,
   output logic                sel_err
);

   localparam int              CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [SELW-1:0] LAST_CH  = SELW'(NCH - 1);
   localparam logic [CW-1:0]   LAST_CNT = CW'(DWELL - 1);
   localparam logic [SELW:0]   NCH_X    = (SELW + 1)'(NCH);

   // Unpack the channel bus.
   logic [W-1:0] ch [NCH];
   generate
      for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
         assign ch[gi] = d[gi*W +: W];
      end
   endgenerate

   logic [W-1:0]    q_reg,           q_next;
   logic            q_valid_reg,     q_valid_next;
   logic [SELW-1:0] cur_sel_reg,     cur_sel_next;
   logic            scan_wrap_reg,   scan_wrap_next;
   logic            sel_err_reg,     sel_err_next;
   logic [SELW-1:0] ptr_reg,         ptr_next;
   logic [CW-1:0]   cnt_reg,         cnt_next;
   // Set while the last enabled edge was a scan edge; a clear flag on a scan
   // edge marks manual->scan entry.
   logic            scan_active_reg, scan_active_next;
   // The pointer wrapped on the previous scan advance; the next scan sample
   // (channel 0) carries the scan_wrap tag.
   logic            wrap_pend_reg,   wrap_pend_next;

   logic [SELW-1:0] ptr_eff;
   logic [SELW-1:0] ptr_inc;
   logic [CW-1:0]   cnt_eff;
   logic [SELW-1:0] eff;
   logic [W-1:0]    eff_data;
   logic            sel_ok;

   always_comb begin
      // On manual->scan entry the scan starts on the channel last shown, with
      // a fresh dwell, so that channel gets a full DWELL.
      ptr_eff  = scan_active_reg ? ptr_reg : cur_sel_reg;
      cnt_eff  = scan_active_reg ? cnt_reg : '0;
      ptr_inc  = (ptr_eff == LAST_CH) ? '0 : ptr_eff + 1'b1;
      sel_ok   = ({1'b0, select} < NCH_X);
      eff      = mode ? ptr_eff : select;
      eff_data = '0;
      for (int k = 0; k < NCH; k++) begin
         if (eff == SELW'(k)) eff_data = ch[k];
      end
   end

   always_comb begin
      q_next           = q_reg;
      q_valid_next     = q_valid_reg;
      cur_sel_next     = cur_sel_reg;
      scan_wrap_next   = 1'b0;
      sel_err_next     = sel_err_reg;
      ptr_next         = ptr_reg;
      cnt_next         = cnt_reg;
      scan_active_next = scan_active_reg;
      wrap_pend_next   = wrap_pend_reg;

      if (en) begin
         if (mode) begin
            q_next           = eff_data;
            q_valid_next     = 1'b1;
            cur_sel_next     = ptr_eff;
            scan_active_next = 1'b1;
            scan_wrap_next   = wrap_pend_reg;
            if (cnt_eff == LAST_CNT) begin
               cnt_next       = '0;
               ptr_next       = ptr_inc;
               wrap_pend_next = (ptr_eff == LAST_CH);
            end else begin
               cnt_next       = cnt_eff + 1'b1;
               ptr_next       = ptr_eff;
               wrap_pend_next = 1'b0;
            end
         end else begin
            cnt_next         = '0;
            scan_active_next = 1'b0;
            wrap_pend_next   = 1'b0;
            if (sel_ok) begin
               q_next       = eff_data;
               q_valid_next = 1'b1;
               cur_sel_next = select;
            end else begin
               q_next       = '0;
               q_valid_next = 1'b0;
               sel_err_next = 1'b1;
            end
         end
      end else begin
         q_valid_next = 1'b0;
`ifdef MUXN_HOLD_EN
         q_next       = q_reg;
`else
         q_next       = '0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_reg           <= '0;
         q_valid_reg     <= 1'b0;
         cur_sel_reg     <= '0;
         scan_wrap_reg   <= 1'b0;
         sel_err_reg     <= 1'b0;
         ptr_reg         <= '0;
         cnt_reg         <= '0;
         scan_active_reg <= 1'b0;
         wrap_pend_reg   <= 1'b0;
      end else begin
         q_reg           <= q_next;
         q_valid_reg     <= q_valid_next;
         cur_sel_reg     <= cur_sel_next;
         scan_wrap_reg   <= scan_wrap_next;
         sel_err_reg     <= sel_err_next;
         ptr_reg         <= ptr_next;
         cnt_reg         <= cnt_next;
         scan_active_reg <= scan_active_next;
         wrap_pend_reg   <= wrap_pend_next;
      end
   end

   assign q         = q_reg;
   assign q_valid   = q_valid_reg;
   assign cur_sel   = cur_sel_reg;
   assign scan_wrap = scan_wrap_reg;
   assign sel_err   = sel_err_reg;

endmodule
